// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, owner encoding and the
// latency-counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Counter must hold MEM_LAT-1; one spare bit keeps MEM_LAT=1 at width 1.
    function automatic int lat_cnt_w(input int mem_lat);
        return $clog2(mem_lat) + 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector. Fixed D-over-I priority by default; with
// MEM_ARB_ROUND_ROBIN_EN defined, collisions go to the side not served last.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant_owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
        end else if (i_req) begin
            grant_owner = OWN_I;
        end
`else
        if (i_req && !d_req) begin
            grant_owner = OWN_I;
        end
`endif
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history; the port stays for a uniform interface.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported fixed-latency memory between instruction fetch and
// the data side. Optional round-robin arbitration via MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = lat_cnt_w(MEM_LAT);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    owner_t            owner;
    owner_t            last_owner;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              grant_valid;
    owner_t            grant_owner;

    mem_arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: default assignment first, so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (grant_valid) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Command latch, latency counter and per-side read data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            owner      <= OWN_I;
            last_owner <= OWN_D;
            cmd_wr     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_owner;
                        last_owner <= grant_owner;
                        if (grant_owner == OWN_D) begin
                            cmd_wr    <= d_wr;
                            cmd_addr  <= d_addr;
                            cmd_wdata <= d_wdata;
                        end else begin
                            cmd_wr    <= 1'b0;
                            cmd_addr  <= i_addr;
                            cmd_wdata <= '0;
                        end
                    end
                end
                ISSUE: cnt <= CNT_W'(MEM_LAT - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        // A write leaves d_rdata holding the last read value.
                        if (owner == OWN_I) begin
                            i_rdata <= mem_rdata;
                        end else if (!cmd_wr) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        busy      = (state != IDLE);
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
        unique case (state)
            ISSUE: begin
                mem_en = 1'b1;
                mem_wr = cmd_wr;
            end
            RESP: begin
                i_ack = (owner == OWN_I);
                d_ack = (owner == OWN_D);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model
// predicts grants, memory commands, acks and busy windows per cycle.
module tb_mem_arbiter;

    parameter int MEM_LAT = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req = 1'b0;
    logic              d_wr = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [15:0] rdata;
    } ack_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        bit          wr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    ack_t ackq[$];
    cmd_t cmdq[$];
    rd_t  devq[$];

    logic [15:0] model_mem [logic [15:0]];
    logic [15:0] dev_mem   [logic [15:0]];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_on = 0;
    int reset_check_cyc = -1;
    int free_cyc = 0;
    int busy_from = 1;
    int busy_to = 0;
    int cur_grant = -100;
    int n_resets = 0;

    bit i_act = 0, d_act = 0;
    bit i_granted = 0, d_granted = 0;
    int i_done = 0, d_done = 0;
    bit last_was_d = 1;
    logic [15:0] last_d_rd = '0;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus, memory device and reference model.
    task automatic step(input int pct, input bit allow_reset);
        bit i_drop, d_drop, i_pend, d_pend, pick_d;
        int ack_cyc;
        logic [15:0] a, rd;
        @(posedge clk);
        cyc++;
        #1;
        // Memory device: fixed-latency read pipe, writes land on mem_en.
        if (mem_en === 1'b1) begin
            if (mem_wr === 1'b1) dev_mem[mem_addr] = mem_wdata;
            else devq.push_back('{cyc + MEM_LAT,
                                  dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr)});
        end
        while (devq.size() > 0 && devq[0].due < cyc) void'(devq.pop_front());
        if (devq.size() > 0 && devq[0].due == cyc) mem_rdata = devq.pop_front().data;
        else mem_rdata = 16'($urandom);
        rst_n = 1'b1;

        if (allow_reset && cyc == cur_grant + 2 && $urandom_range(0, 5) == 0) begin
            rst_n = 1'b0;
            i_req = 1'b0; d_req = 1'b0;
            i_act = 0; d_act = 0; i_granted = 0; d_granted = 0;
            ackq.delete(); cmdq.delete(); devq.delete();
            busy_to = cyc;
            free_cyc = cyc + 1;
            last_was_d = 1;
            last_d_rd = '0;
            reset_check_cyc = cyc + 1;
            cur_grant = -100;
            n_resets++;
            return;
        end

        i_drop = 0; d_drop = 0;
        if (i_granted && cyc == i_done) begin
            i_req = 1'b0; i_act = 0; i_granted = 0; i_drop = 1;
        end
        if (d_granted && cyc == d_done) begin
            d_req = 1'b0; d_act = 0; d_granted = 0; d_drop = 1;
        end
        if (!i_act && !i_drop && $urandom_range(0, 99) < pct) begin
            i_act = 1; i_req = 1'b1; i_addr = 16'($urandom_range(0, 31));
        end
        if (!d_act && !d_drop && $urandom_range(0, 99) < pct) begin
            d_act = 1; d_req = 1'b1;
            d_wr = 1'($urandom_range(0, 1));
            d_addr = 16'($urandom_range(0, 31));
            d_wdata = 16'($urandom);
        end

        i_pend = i_act && !i_granted;
        d_pend = d_act && !d_granted;
        if (cyc >= free_cyc && (i_pend || d_pend)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_d = (i_pend && d_pend) ? !last_was_d : d_pend;
`else
            pick_d = d_pend;
`endif
            last_was_d = pick_d;
            ack_cyc = cyc + 2 + MEM_LAT;
            busy_from = cyc + 1;
            busy_to = ack_cyc;
            free_cyc = ack_cyc + 1;
            cur_grant = cyc;
            if (pick_d) begin
                d_granted = 1; d_done = ack_cyc;
                a = d_addr;
                if (d_wr) begin
                    model_mem[a] = d_wdata;
                    cmdq.push_back('{cyc + 1, a, 1'b1, d_wdata});
                    ackq.push_back('{ack_cyc, 1'b1, last_d_rd});
                end else begin
                    rd = model_mem.exists(a) ? model_mem[a] : init_val(a);
                    last_d_rd = rd;
                    cmdq.push_back('{cyc + 1, a, 1'b0, 16'h0});
                    ackq.push_back('{ack_cyc, 1'b1, rd});
                end
            end else begin
                i_granted = 1; i_done = ack_cyc;
                a = i_addr;
                rd = model_mem.exists(a) ? model_mem[a] : init_val(a);
                cmdq.push_back('{cyc + 1, a, 1'b0, 16'h0});
                ackq.push_back('{ack_cyc, 1'b0, rd});
            end
        end
    endtask

    // Monitor: compares every DUT output cycle against the model's queues.
    initial begin
        bit exp_en, exp_ack, exp_i, exp_d;
        cmd_t c;
        ack_t k;
        forever begin
            @(posedge clk);
            #2;
            if (mon_on) begin
                while (cmdq.size() > 0 && cmdq[0].cyc < cyc) void'(cmdq.pop_front());
                while (ackq.size() > 0 && ackq[0].cyc < cyc) void'(ackq.pop_front());
                exp_en = (cmdq.size() > 0 && cmdq[0].cyc == cyc);
                check("mem_en", 32'(mem_en), 32'(exp_en));
                if (exp_en) begin
                    c = cmdq.pop_front();
                    check("mem_wr", 32'(mem_wr), 32'(c.wr));
                    check("mem_addr", 32'(mem_addr), 32'(c.addr));
                    if (c.wr) check("mem_wdata", 32'(mem_wdata), 32'(c.wdata));
                end else begin
                    check("mem_wr_outside_issue", 32'(mem_wr), 32'd0);
                end
                exp_ack = (ackq.size() > 0 && ackq[0].cyc == cyc);
                exp_i = exp_ack && !ackq[0].is_d;
                exp_d = exp_ack && ackq[0].is_d;
                check("i_ack", 32'(i_ack), 32'(exp_i));
                check("d_ack", 32'(d_ack), 32'(exp_d));
                if (exp_ack) begin
                    k = ackq.pop_front();
                    if (k.is_d) check("d_rdata", 32'(d_rdata), 32'(k.rdata));
                    else check("i_rdata", 32'(i_rdata), 32'(k.rdata));
                end
                check("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
                if (cyc == reset_check_cyc) begin
                    check("reset_ctrl", 32'({i_ack, d_ack, mem_en, mem_wr, busy}), 32'd0);
                    check("reset_rdata", {i_rdata, d_rdata}, 32'd0);
                    check("reset_cmd", {mem_addr, mem_wdata}, 32'd0);
                end
            end
        end
    end

    initial begin
        repeat (3) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        reset_check_cyc = cyc + 1;
        free_cyc = cyc + 1;
        mon_on = 1;
        repeat (300)  step(5, 1'b0);
        repeat (1500) step(60, 1'b1);
        repeat (400)  step(100, 1'b0);
        repeat (3 * (MEM_LAT + 3) + 5) step(0, 1'b0);
        #3;
        check("ack_queue_drained", ackq.size(), 32'd0);
        check("cmd_queue_drained", cmdq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
